bus_rr_fabric: RTL and testbench
================================

// Module: bus_rr_fabric
// PURPOSE
//  Parametrised shared data bus: NSRC sources contend for one WIDTH-bit bus and
//  each names one of NDST destinations. A round-robin arbiter grants one source
//  per cycle, subject to the target's ready. The winning word is registered onto
//  the bus with a one-hot per-destination valid strobe.
//  Successor to the fixed 8-bit 2-in/2-out bus for multi-register/ALU datapaths.
// PARAMETERS
//  WIDTH  8  data width in bits
//  NSRC   4  number of sources (>=2)
//  NDST   4  number of destinations (>=2)
//  DSELW  2  destination-select width, = clog2(NDST)
// PORTS
//  clk        in   1            system clock, rising edge
//  rst        in   1            synchronous reset, active-high
//  src_req    in   NSRC         per-source request
//  src_dst    in   NSRC*DSELW   per-source destination index, source i at [i*DSELW +: DSELW]
//  src_data   in   NSRC*WIDTH   per-source data, source i at [i*WIDTH +: WIDTH]
//  src_ack    out  NSRC         one-hot, combinational grant; the source's word is taken this cycle
//  dst_rdy    in   NDST         per-destination ready to accept
//  bus_data   out  WIDTH        registered bus word
//  dst_vld    out  NDST         registered one-hot valid; destination d consumes bus_data when dst_vld[d]
//  busy       out  1            registered: a transfer was issued last cycle (= |dst_vld)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): bus_data=0, dst_vld=0, busy=0, rr pointer=0.
//    src_ack=0 whenever rst=1. Reset mid-transfer discards the pending word.
//  - Eligibility: eligible[i] = src_req[i] & dst_rdy[src_dst[i]] & (src_dst[i] < NDST).
//    Out-of-range dst is never eligible and never acked.
//  - Arbitration: round-robin over eligible sources, starting at pointer ptr.
//    Winner g is the first eligible index in ptr, ptr+1, ..., NSRC-1, 0, ... (wrap).
//  - src_ack[g]=1 in the same cycle, combinationally; at most one ack bit is high.
//    No eligible source -> src_ack=0, ptr unchanged.
//  - On grant, at the next clk edge:
//    - bus_data <= src_data[g]
//    - dst_vld <= onehot(src_dst[g])
//    - busy <= 1
//    - ptr <= (g+1) mod NSRC
//  - No grant: dst_vld <= 0 and busy <= 0; bus_data holds its last value.
//  - Latency: ack at cycle t -> data/valid visible from cycle t+1 for exactly one cycle.
//  - Throughput: one word per cycle. Back-to-back grants are allowed, including to the same destination.
//  - Fairness: a continuously eligible source is granted within NSRC cycles.
//  - Simultaneous requests to the same destination are serialised by round-robin.
//    Requests to different destinations still share the single bus: one per cycle.
//  - dst_rdy is sampled in the grant cycle only. Deasserting dst_rdy after the ack
//    does not cancel the registered transfer.
//  - A source must hold req/dst/data until acked; the block keeps no request state.
// STRUCTURE
//  - Shared include bus_defs.vh: default WIDTH/NSRC/NDST and a clog2 function.
//  - Sub-module rr_arbiter (params N): inputs clk, rst, elig[N]; outputs one-hot gnt[N].
//    Owns the pointer and its update; reusable for the memory-port arbiter.
//  - Top level: eligibility decode, NSRC:1 data mux on gnt, output register stage.
// TESTING
//  1. rst=1 for 2 cycles with all req high -> src_ack=0, dst_vld=0, bus_data=0, busy=0.
//  2. Only src2 requests: dst=3, data=8'hA5, all rdy -> ack[2] at t; at t+1 bus_data=A5,
//     dst_vld=4'b1000, busy=1; at t+2 dst_vld=0.
//  3. All 4 sources request continuously, all rdy -> grant order 0,1,2,3,0,1, one per cycle;
//     each data word appears on the bus exactly once per grant.
//  4. src0->dst1 with dst_rdy[1]=0, src1->dst2 with rdy=1 -> src1 acked, src0 waits.
//     Raise dst_rdy[1] -> src0 acked next.
//  5. Grant at t, assert rst at t+1 -> dst_vld=0 and ptr=0 after that edge;
//     the next arbitration restarts at src0.
//  6. Parameter sweep WIDTH=16, NSRC=3, NDST=2 -> ptr wraps 2->0;
//     src_dst=3 (out of range) is never acked.

Source files
------------

// File: rtl/bus_rr_fabric_pkg.sv
// Shared defaults and helpers for the round-robin bus fabric.
package bus_rr_fabric_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_NSRC  = 4;
   localparam int DEF_NDST  = 4;

   // Index width for n items; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bus_rr_fabric_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first eligible index at or after
// the pointer, wrapping; the pointer moves to just past the winner.
module rr_arbiter
   import bus_rr_fabric_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] elig,
   output logic [N-1:0] gnt
);

   localparam int PW = idx_w(N);

   logic [PW-1:0] ptr_q, ptr_d;
   logic          found;

   // Search ptr..N-1 first, then 0..ptr-1, so the scan order wraps at N.
   always_comb begin
      gnt   = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && elig[i] && (i >= int'(ptr_q))) begin
            found  = 1'b1;
            gnt[i] = 1'b1;
            ptr_d  = PW'((i + 1) % N);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && elig[i] && (i < int'(ptr_q))) begin
            found  = 1'b1;
            gnt[i] = 1'b1;
            ptr_d  = PW'((i + 1) % N);
         end
      end
   end

   // Pointer register; holds when nothing is granted.
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/bus_rr_fabric.sv
// Shared data bus: NSRC sources contend through a round-robin arbiter; the
// winning word is registered onto the bus with a one-hot destination strobe.
module bus_rr_fabric
   import bus_rr_fabric_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NSRC  = DEF_NSRC,
   parameter int NDST  = DEF_NDST,
   parameter int DSELW = idx_w(NDST)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NSRC-1:0]       src_req,
   input  logic [NSRC*DSELW-1:0] src_dst,
   input  logic [NSRC*WIDTH-1:0] src_data,
   output logic [NSRC-1:0]       src_ack,
   input  logic [NDST-1:0]       dst_rdy,
   output logic [WIDTH-1:0]      bus_data,
   output logic [NDST-1:0]       dst_vld,
   output logic                  busy
);

   // Handshake: src_ack[i] is a combinational grant; the source's word is
   // taken in that cycle and appears on the bus for exactly the next cycle.

   logic [NSRC-1:0]  elig;
   logic [NSRC-1:0]  gnt;
   logic [WIDTH-1:0] bus_data_q, bus_data_d;
   logic [NDST-1:0]  dst_vld_q, dst_vld_d;
   logic             busy_q, busy_d;

   // Eligible when requesting a ready, in-range destination; nothing during reset.
   // Matching against each legal index makes out-of-range selects never eligible.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NSRC; i++) begin
         for (int d = 0; d < NDST; d++) begin
            if (!rst && src_req[i] && dst_rdy[d] &&
                (src_dst[i*DSELW +: DSELW] == DSELW'(d)))
               elig[i] = 1'b1;
         end
      end
   end

   rr_arbiter #(.N(NSRC)) u_arb (
      .clk  (clk),
      .rst  (rst),
      .elig (elig),
      .gnt  (gnt)
   );

   assign src_ack = gnt;

   // Select the granted word and destination for the output register.
   always_comb begin
      bus_data_d = bus_data_q;
      dst_vld_d  = '0;
      busy_d     = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (gnt[i]) begin
            bus_data_d = src_data[i*WIDTH +: WIDTH];
            busy_d     = 1'b1;
            for (int d = 0; d < NDST; d++)
               dst_vld_d[d] = (src_dst[i*DSELW +: DSELW] == DSELW'(d));
         end
      end
   end

   // Output register stage; reset drops any word captured in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus_data_q <= '0;
         dst_vld_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         bus_data_q <= bus_data_d;
         dst_vld_q  <= dst_vld_d;
         busy_q     <= busy_d;
      end
   end

   assign bus_data = bus_data_q;
   assign dst_vld  = dst_vld_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_bus_rr_fabric.sv
// Directed bench for bus_rr_fabric: a vector table on the default 8/4/4
// instance plus hand-written sequences on a 16-bit, 3-source, 2-destination one.
module tb_bus_rr_fabric;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT A: WIDTH=8, NSRC=4, NDST=4 ----------------
   logic        rst_a;
   logic [3:0]  req_a;
   logic [7:0]  dst_a;
   logic [31:0] data_a;
   logic [3:0]  ack_a;
   logic [3:0]  rdy_a;
   logic [7:0]  bus_a;
   logic [3:0]  vld_a;
   logic        busy_a;

   bus_rr_fabric dut_a (
      .clk      (clk),
      .rst      (rst_a),
      .src_req  (req_a),
      .src_dst  (dst_a),
      .src_data (data_a),
      .src_ack  (ack_a),
      .dst_rdy  (rdy_a),
      .bus_data (bus_a),
      .dst_vld  (vld_a),
      .busy     (busy_a)
   );

   // ---------------- DUT B: WIDTH=16, NSRC=3, NDST=2, DSELW=2 ----------------
   logic        rst_b;
   logic [2:0]  req_b;
   logic [5:0]  dst_b;
   logic [47:0] data_b;
   logic [2:0]  ack_b;
   logic [1:0]  rdy_b;
   logic [15:0] bus_b;
   logic [1:0]  vld_b;
   logic        busy_b;

   bus_rr_fabric #(.WIDTH(16), .NSRC(3), .NDST(2), .DSELW(2)) dut_b (
      .clk      (clk),
      .rst      (rst_b),
      .src_req  (req_b),
      .src_dst  (dst_b),
      .src_data (data_b),
      .src_ack  (ack_b),
      .dst_rdy  (rdy_b),
      .bus_data (bus_b),
      .dst_vld  (vld_b),
      .busy     (busy_b)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [15:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   // exp_ack is checked in the apply cycle; exp_vld/exp_bus/exp_busy after the next edge.
   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [7:0]  dst;
      logic [31:0] data;
      logic [3:0]  rdy;
      logic [3:0]  exp_ack;
      logic [3:0]  exp_vld;
      logic [7:0]  exp_bus;
      logic        exp_busy;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [3:0] rq, input logic [7:0] ds,
                      input logic [31:0] dt, input logic [3:0] rd, input logic [3:0] ea,
                      input logic [3:0] ev, input logic [7:0] eb, input logic ey);
      vec_t v;
      v.rst = r; v.req = rq; v.dst = ds; v.data = dt; v.rdy = rd;
      v.exp_ack = ea; v.exp_vld = ev; v.exp_bus = eb; v.exp_busy = ey;
      vecs.push_back(v);
   endtask

   // ---------------- driver for DUT B ----------------
   task automatic drive_b(input logic r, input logic [2:0] rq, input logic [5:0] ds);
      rst_b = r;
      req_b = rq;
      dst_b = ds;
      #1;
   endtask

   localparam logic [31:0] W4 = 32'h44332211;  // src3..src0 words
   localparam logic [7:0]  D_ID = 8'hE4;        // src i -> dst i

   initial begin
      logic [2:0] seq1_ack[2];
      logic [2:0] seq2_ack[4];
      logic [15:0] words_b[3];

      rst_a = 1'b1; req_a = '0; dst_a = '0; data_a = '0; rdy_a = '0;
      rst_b = 1'b1; req_b = '0; dst_b = '0; rdy_b = 2'b11;
      data_b = {16'h3222, 16'h2111, 16'h1000};
      words_b[0] = 16'h1000; words_b[1] = 16'h2111; words_b[2] = 16'h3222;

      //   rst req      dst   data          rdy      ack      vld      bus    busy
      // reset with everything requesting
      add(1, 4'b1111, D_ID, W4,           4'b1111, 4'b0000, 4'b0000, 8'h00, 0);
      add(1, 4'b1111, D_ID, W4,           4'b1111, 4'b0000, 4'b0000, 8'h00, 0);
      // lone src2 -> dst3, then idle: strobe lasts one cycle, bus holds
      add(0, 4'b0100, 8'h30, 32'h44A52211, 4'b1111, 4'b0100, 4'b1000, 8'hA5, 1);
      add(0, 4'b0000, 8'h30, 32'h44A52211, 4'b1111, 4'b0000, 4'b0000, 8'hA5, 0);
      // reset to bring the pointer back to 0
      add(1, 4'b0000, D_ID, W4,           4'b1111, 4'b0000, 4'b0000, 8'h00, 0);
      // all request continuously: 0,1,2,3,0,1
      add(0, 4'b1111, D_ID, W4,           4'b1111, 4'b0001, 4'b0001, 8'h11, 1);
      add(0, 4'b1111, D_ID, W4,           4'b1111, 4'b0010, 4'b0010, 8'h22, 1);
      add(0, 4'b1111, D_ID, W4,           4'b1111, 4'b0100, 4'b0100, 8'h33, 1);
      add(0, 4'b1111, D_ID, W4,           4'b1111, 4'b1000, 4'b1000, 8'h44, 1);
      add(0, 4'b1111, D_ID, W4,           4'b1111, 4'b0001, 4'b0001, 8'h11, 1);
      add(0, 4'b1111, D_ID, W4,           4'b1111, 4'b0010, 4'b0010, 8'h22, 1);
      // src0->dst1 (not ready), src1->dst2 (ready): src1 wins, src0 waits
      add(0, 4'b0011, 8'h09, W4,          4'b1101, 4'b0010, 4'b0100, 8'h22, 1);
      add(0, 4'b0001, 8'h09, W4,          4'b1101, 4'b0000, 4'b0000, 8'h22, 0);
      add(0, 4'b0001, 8'h09, W4,          4'b1111, 4'b0001, 4'b0010, 8'h11, 1);
      // all to dst0, only dst0 ready: back-to-back to same destination (ptr=1)
      add(0, 4'b1111, 8'h00, W4,          4'b0001, 4'b0010, 4'b0001, 8'h22, 1);
      add(0, 4'b1111, 8'h00, W4,          4'b0001, 4'b0100, 4'b0001, 8'h33, 1);
      // grant src3, then reset: transfer discarded, restart at src0
      add(0, 4'b1111, D_ID, W4,           4'b1111, 4'b1000, 4'b1000, 8'h44, 1);
      add(1, 4'b1111, D_ID, W4,           4'b1111, 4'b0000, 4'b0000, 8'h00, 0);
      add(0, 4'b1111, D_ID, W4,           4'b1111, 4'b0001, 4'b0001, 8'h11, 1);

      @(posedge clk); #1;
      foreach (vecs[k]) begin
         rst_a  = vecs[k].rst;
         req_a  = vecs[k].req;
         dst_a  = vecs[k].dst;
         data_a = vecs[k].data;
         rdy_a  = vecs[k].rdy;
         #1;
         check($sformatf("v%0d src_ack", k), 64'(ack_a), 64'(vecs[k].exp_ack));
         @(posedge clk); #1;
         check($sformatf("v%0d dst_vld", k), 64'(vld_a), 64'(vecs[k].exp_vld));
         check($sformatf("v%0d bus_data", k), 64'(bus_a), 64'(vecs[k].exp_bus));
         check($sformatf("v%0d busy", k), 64'(busy_a), 64'(vecs[k].exp_busy));
      end
      rst_a = 1'b0; req_a = '0;

      // ---- DUT B: reset state with all requesting ----
      drive_b(1'b1, 3'b111, 6'b00_11_00);
      check("b_rst src_ack", 64'(ack_b), 64'd0);
      @(posedge clk); #1;
      check("b_rst dst_vld", 64'(vld_b), 64'd0);
      check("b_rst bus_data", 64'(bus_b), 64'd0);
      check("b_rst busy", 64'(busy_b), 64'd0);

      // ---- src1 targets dst3 (out of range): never acked; 0 and 2 alternate ----
      seq1_ack[0] = 3'b001; seq1_ack[1] = 3'b100;
      for (int k = 0; k < 6; k++) begin
         drive_b(1'b0, 3'b111, 6'b00_11_00);
         check($sformatf("b_oor%0d src_ack", k), 64'(ack_b), 64'(seq1_ack[k % 2]));
         exp_q.push_back(words_b[(k % 2) * 2]);
         @(posedge clk); #1;
         check($sformatf("b_oor%0d bus_data", k), 64'(bus_b), 64'(exp_q.pop_front()));
         check($sformatf("b_oor%0d dst_vld", k), 64'(vld_b), 64'(2'b01));
      end

      // ---- only the out-of-range source requests: nothing happens ----
      drive_b(1'b0, 3'b010, 6'b00_11_00);
      check("b_lone_oor src_ack", 64'(ack_b), 64'd0);
      @(posedge clk); #1;
      check("b_lone_oor busy", 64'(busy_b), 64'd0);
      check("b_lone_oor bus_data", 64'(bus_b), 64'(16'h3222));

      // ---- all in range to dst1: 0,1,2 then wrap to 0 ----
      seq2_ack[0] = 3'b001; seq2_ack[1] = 3'b010; seq2_ack[2] = 3'b100; seq2_ack[3] = 3'b001;
      for (int k = 0; k < 4; k++) begin
         drive_b(1'b0, 3'b111, 6'b01_01_01);
         check($sformatf("b_wrap%0d src_ack", k), 64'(ack_b), 64'(seq2_ack[k]));
         exp_q.push_back(words_b[k % 3]);
         @(posedge clk); #1;
         check($sformatf("b_wrap%0d bus_data", k), 64'(bus_b), 64'(exp_q.pop_front()));
         check($sformatf("b_wrap%0d dst_vld", k), 64'(vld_b), 64'(2'b10));
         check($sformatf("b_wrap%0d busy", k), 64'(busy_b), 64'd1);
      end
      drive_b(1'b0, 3'b000, 6'b00_00_00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
